// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with a small circular queue feeding
// Decode. One fetch is outstanding at most; a redirect (pc_src) flushes the
// queue and either drops or discards the in-flight response.
module fetch_queue #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter int              DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [WORD-1:0]        imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_LEN-1:0]   imem_rdata,
  input  logic                   pc_src,
  input  logic [WORD-1:0]        branch_target,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_LEN-1:0]   instruction,
  output logic [WORD-1:0]        pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  // WAIT: request in flight, response will be queued.
  // DROP: request in flight, response belongs to a squashed path.
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WORD-1:0]        r_fetch_pc;
  logic [PW-1:0]          r_head, r_tail;
  logic [PW:0]            r_count;
  logic [WORD-1:0]        r_pc_mem  [DEPTH];
  logic [INSTR_LEN-1:0]   r_ins_mem [DEPTH];

  logic                   w_push, w_pop, w_flush, w_full;
  logic [WORD-1:0]        w_target;

  // Branch targets are word aligned; low two bits are cleared.
  assign w_target  = branch_target & ~WORD'(3);
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_flush   = pc_src;

  // A redirect cycle never issues a fetch (the address would be stale),
  // and reset gates the request since it acts asynchronously.
  assign imem_req  = reset && (r_state == IDLE) && !w_full && !pc_src;
  assign imem_addr = r_fetch_pc;

  assign instr_valid = (r_count != '0);
  assign instruction = instr_valid ? r_ins_mem[r_head] : '0;
  assign pc          = instr_valid ? r_pc_mem[r_head]  : '0;
  assign count       = r_count;
  assign w_pop       = instr_valid && instr_ready && !pc_src;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and push decision; responses in IDLE are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE: if (imem_req) w_state_nxt = WAIT;
      WAIT: begin
        if (pc_src)           w_state_nxt = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DROP: if (imem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch PC: redirect wins, otherwise advance past each accepted response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_fetch_pc <= RESET_PC;
    else if (pc_src) r_fetch_pc <= w_target;
    else if (w_push) r_fetch_pc <= r_fetch_pc + WORD'(4);
  end

  // Queue pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; only occupied entries are ever read, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]  <= r_fetch_pc;
      r_ins_mem[r_tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model of the fetch unit.
module tb_fetch_queue;
  localparam int              WORD = 64, IL = 32, DEPTH = 4;
  localparam logic [63:0]     RPC  = 64'h0;

  logic            clk = 1'b0, reset;
  logic            imem_req, imem_rvalid, pc_src, instr_valid, instr_ready;
  logic [63:0]     imem_addr, branch_target, pc;
  logic [31:0]     imem_rdata, instruction;
  logic [2:0]      count;

  fetch_queue #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_src(pc_src),
    .branch_target(branch_target), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .pc(pc), .count(count));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of {pc,instr}, next fetch address, and whether a fetch is in
  // flight and whether its answer is to be thrown away.
  logic [95:0] mq[$];
  logic [63:0] m_fpc;
  bit          m_out, m_drop;
  int          m_pops;

  bit          chk_en = 0, rec_en = 0, auto_mem = 0, rdy_follow = 0, mem_pend = 0;
  logic [31:0] s_rd = 32'h0;
  logic [63:0] addr_q[$];

  function automatic bit exp_req();
    return !m_out && (mq.size() < DEPTH) && !pc_src;
  endfunction

  task automatic model_reset();
    mq.delete(); m_fpc = RPC; m_out = 0; m_drop = 0; mem_pend = 0;
  endtask

  task automatic model_step();
    bit req, pop;
    logic [63:0] tgt;
    logic [95:0] dmy;
    req = exp_req();
    pop = (mq.size() != 0) && instr_ready && !pc_src;
    tgt = {branch_target[63:2], 2'b00};
    if (pc_src) begin
      mq.delete();
      m_fpc = tgt;
      if (m_out && imem_rvalid) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
    end else begin
      if (pop) begin dmy = mq.pop_front(); m_pops++; end
      if (m_out && imem_rvalid) begin
        if (!m_drop) begin
          mq.push_back({m_fpc, imem_rdata});
          m_fpc = m_fpc + 64'd4;
        end
        m_out = 0; m_drop = 0;
      end
      if (req) m_out = 1;
    end
    mem_pend = req;
  endtask

  // Per-cycle comparison of every output against the model.
  logic [95:0] h;
  always @(negedge clk) begin
    if (chk_en) begin
      h = (mq.size() != 0) ? mq[0] : 96'h0;
      chk("imem_req", 64'(imem_req), 64'(exp_req()));
      chk("imem_addr", imem_addr, m_fpc);
      chk("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
      chk("count", 64'(count), 64'(mq.size()));
      chk("pc", pc, h[95:32]);
      chk("instruction", 64'(instruction), 64'(h[31:0]));
      if (rec_en && imem_req) addr_q.push_back(imem_addr);
    end
  end

  task automatic drive(input bit ps, input logic [63:0] tgt, input bit rv, input bit rdy);
    pc_src        = ps;
    branch_target = tgt;
    imem_rvalid   = auto_mem ? mem_pend : rv;
    imem_rdata    = s_rd;
    instr_ready   = rdy_follow ? imem_rvalid : rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 64'h0, 0, 0);
    model_reset();
    #12;
    chk("rst_imem_req", 64'(imem_req), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_instr_valid", 64'(instr_valid), 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instruction", 64'(instruction), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1;

    // Fill with fixed data, memory answers one cycle after each request.
    auto_mem = 1; rec_en = 1; s_rd = 32'h8B020020;
    for (int i = 0; i < 10; i++) begin drive(0, 64'h0, 0, 0); tick(); end
    rec_en = 0;
    drive(0, 64'h0, 0, 0); #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_req", 64'(imem_req), 64'h0);
    chk("fill_pc", pc, 64'h0);
    chk("fill_instr", 64'(instruction), 64'h8B020020);
    chk("fill_nreq", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("fill_addr", (i < addr_q.size()) ? addr_q[i] : 64'hFFFF, 64'(i * 4));

    // One pop from a full queue reopens fetch at 16.
    drive(0, 64'h0, 0, 1); tick();
    drive(0, 64'h0, 0, 0); #1;
    chk("pop_count", 64'(count), 64'd3);
    chk("pop_req", 64'(imem_req), 64'h1);
    chk("pop_addr", imem_addr, 64'h10);
    chk("pop_pc", pc, 64'h4);
    tick();

    // Redirect while waiting, response arrives two cycles later and is dropped.
    auto_mem = 0;
    drive(1, 64'h103, 0, 0); tick();
    drive(0, 64'h0, 0, 0);   tick();
    drive(0, 64'h0, 1, 0);   tick();
    drive(0, 64'h0, 0, 0); #1;
    chk("drop_count", 64'(count), 64'h0);
    chk("drop_req", 64'(imem_req), 64'h1);
    chk("drop_addr", imem_addr, 64'h100);
    tick();

    // Redirect and response in the same waiting cycle.
    drive(1, 64'h40, 1, 0); tick();
    drive(0, 64'h0, 0, 0); #1;
    chk("same_count", 64'(count), 64'h0);
    chk("same_req", 64'(imem_req), 64'h1);
    chk("same_addr", imem_addr, 64'h40);

    // Build two entries, then push+pop together eight times (pointers wrap).
    auto_mem = 1;
    for (int i = 0; i < 20 && mq.size() != 2; i++) begin
      s_rd = $urandom; drive(0, 64'h0, 0, 0); tick();
    end
    chk("pp_pre_count", 64'(count), 64'd2);
    m_pops = 0; rdy_follow = 1;
    for (int i = 0; i < 40 && m_pops < 8; i++) begin
      s_rd = $urandom; drive(0, 64'h0, 0, 0); tick();
    end
    rdy_follow = 0;
    drive(0, 64'h0, 0, 0); #1;
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_pc", pc, 64'h60);

    // Reset in the middle of an outstanding fetch.
    tick();
    chk_en = 0; auto_mem = 0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", 64'(imem_req), 64'h0);
    chk("mid_rst_count", 64'(count), 64'h0);
    chk("mid_rst_valid", 64'(instr_valid), 64'h0);
    chk("mid_rst_pc", pc, 64'h0);
    chk("mid_rst_instr", 64'(instruction), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    drive(0, 64'h0, 0, 0); #1;
    chk("post_rst_req", 64'(imem_req), 64'h1);
    chk("post_rst_addr", imem_addr, RPC);
    chk_en = 1;

    // Random traffic with alternating drain-heavy and stall-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      s_rd = $urandom;
      drive(($urandom % 8) == 0, {$urandom, $urandom}, $urandom % 2,
            ((i / 200) % 2 == 0) ? ($urandom % 4 != 0) : ($urandom % 5 == 0));
      tick();
    end

    @(posedge clk); #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WORD, default 64, width of addresses and PC values.
REQ-002 Parameter INSTR_LEN, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 imem_req  output  1  one-cycle fetch request to instruction memory.
REQ-008 imem_addr  output  WORD  fetch address, valid while imem_req=1.
REQ-009 imem_rvalid  input  1  instruction memory response valid.
REQ-010 imem_rdata  input  INSTR_LEN  instruction word, valid with imem_rvalid.
REQ-011 pc_src  input  1  redirect strobe (taken branch).
REQ-012 branch_target  input  WORD  redirect address, sampled when pc_src=1.
REQ-013 instr_valid  output  1  head entry available to Decode.
REQ-014 instr_ready  input  1  Decode accepts the head entry.
REQ-015 instruction  output  INSTR_LEN  head entry instruction word.
REQ-016 pc  output  WORD  address of head entry instruction.
REQ-017 count  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-018 Block SHALL hold fetch_pc register, DEPTH-entry circular queue of {pc, instruction}, and FSM with states IDLE, WAIT, DROP.
REQ-019 imem_req SHALL equal (state==IDLE) && (count<DEPTH) && !pc_src; imem_addr SHALL equal fetch_pc.
REQ-020 IDLE -> WAIT on the cycle imem_req=1; at most one request SHALL be outstanding.
REQ-021 WAIT with imem_rvalid=1 and pc_src=0: push {fetch_pc, imem_rdata}, fetch_pc += 4 (modulo 2^WORD), -> IDLE.
REQ-022 WAIT with pc_src=1 and imem_rvalid=0: flush, fetch_pc <= target, -> DROP.
REQ-023 WAIT with pc_src=1 and imem_rvalid=1: response discarded, flush, fetch_pc <= target, -> IDLE.
REQ-024 DROP with imem_rvalid=1: response discarded, -> IDLE; pc_src in DROP updates fetch_pc and stays in DROP unless rvalid also set.
REQ-025 IDLE with pc_src=1: flush, fetch_pc <= target, no request that cycle, stay IDLE.
REQ-026 Redirect target SHALL be branch_target with bits [1:0] forced to zero.
REQ-027 Flush SHALL set count to 0 and reset head/tail pointers; flush overrides a same-cycle pop and push.
REQ-028 Pop occurs when instr_valid && instr_ready && !pc_src; head pointer advances, wrapping DEPTH-1 -> 0.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; push when count==DEPTH SHALL not occur (guaranteed by REQ-019).
REQ-030 instr_valid SHALL equal (count!=0); instruction and pc SHALL be zero when count==0, else head entry.
REQ-031 imem_rvalid in IDLE SHALL be ignored.
REQ-032 Latency: request in cycle N, rvalid in N+k (k>=1), entry visible (instr_valid=1) in cycle N+k+1.
REQ-033 Sustained throughput with single-cycle memory SHALL be one instruction per two cycles.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, instr_valid=0, instruction=0, pc=0; imem_req SHALL be 0 while reset=0.
REQ-035 Reset asserted mid-request SHALL abandon the outstanding fetch; first request after release uses RESET_PC.
REQ-036 First request SHALL occur in the first cycle after reset deasserts.

Verification
REQ-037 Reset release, memory returns rdata=0x8B020020 one cycle after each request, instr_ready=0 -> addresses 0,4,8,12 fetched, count reaches 4, imem_req stays 0, head pc=0 instruction=0x8B020020.
REQ-038 Full queue, instr_ready=1 for one cycle -> count 3, imem_req=1 next cycle at addr 16, head pc=4.
REQ-039 pc_src=1 target=0x103 while in WAIT, rvalid two cycles later -> response dropped, count=0, next imem_addr=0x100.
REQ-040 pc_src and imem_rvalid in same WAIT cycle with target 0x40 -> no push, count=0, next request at 0x40.
REQ-041 count=2 with simultaneous push and pop -> count stays 2, head advances by one entry, pointer wrap 3->0 verified over 8 entries.
REQ-042 reset=0 asserted in WAIT mid-cycle -> outputs zero immediately, after release imem_addr=RESET_PC.
